// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared bitwise logic unit.
// Requesters and the result consumer sit on the master side; the arbiter sits on the slave side.
interface logic_unit_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [3*N_REQ-1:0]  req_op;
  logic [16*N_REQ-1:0] req_a16;
  logic [16*N_REQ-1:0] req_b16;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [15:0]         rsp_y16;
  logic [IDW-1:0]      rsp_id;
  logic [2:0]          rsp_op;

  modport master (
    output req_valid, req_op, req_a16, req_b16, rsp_ready,
    input  req_ready, rsp_valid, rsp_y16, rsp_id, rsp_op
  );

  modport slave (
    input  req_valid, req_op, req_a16, req_b16, rsp_ready,
    output req_ready, rsp_valid, rsp_y16, rsp_id, rsp_op
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 16-bit bitwise logic unit among four
// requesters. One grant per cycle; result held in a single-entry output
// register with valid/ready backpressure.

// One bit of the shared gate array: evaluates the selected opcode on a/b.
module logic_unit_bit_slice (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  // Opcode decode for a single bit position.
  always_comb begin
    y = 1'b0;
    case (op)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: y = a ^ b;
      3'b011: y = ~(a ^ b);
      3'b100: y = ~(a & b);
      3'b101: y = ~(a | b);
      3'b110: y = ~a;
      3'b111: y = a;
      default: y = 1'b0;
    endcase
  end
endmodule

module logic_unit_arbiter #(
  parameter int N_REQ = 4
) (
  input logic clk,
  input logic rst,
  logic_unit_arbiter_if.slave bus
);
  localparam int IDW   = $clog2(N_REQ);
  localparam int VEC_W = 16;

  logic [IDW-1:0]   last;
  logic [IDW-1:0]   gnt;
  logic             any_vld;
  logic             space;
  logic             accept;

  logic [2:0]       op_arr [N_REQ];
  logic [VEC_W-1:0] a_arr  [N_REQ];
  logic [VEC_W-1:0] b_arr  [N_REQ];

  logic [2:0]       op_g;
  logic [VEC_W-1:0] a_g;
  logic [VEC_W-1:0] b_g;
  logic [VEC_W-1:0] y_g;

  // Unpack the flat per-requester buses.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_arr[i] = bus.req_op[3*i +: 3];
    assign a_arr[i]  = bus.req_a16[VEC_W*i +: VEC_W];
    assign b_arr[i]  = bus.req_b16[VEC_W*i +: VEC_W];
  end

  assign any_vld = |bus.req_valid;
  assign space   = !bus.rsp_valid || bus.rsp_ready;
  // Reset suppresses acceptance so a request in the reset cycle is dropped.
  assign accept  = !rst && space && any_vld;

  // Round-robin search starting just after the last winner; the last winner
  // itself is checked last, so a waiting requester keeps its position.
  always_comb begin
    logic [IDW-1:0] cand;
    logic           found;
    gnt   = last;
    found = 1'b0;
    cand  = last;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last + IDW'(k);
      if (!found && bus.req_valid[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end

  // One-hot ready to the winning requester only when the output can take it.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt] = 1'b1;
  end

  assign op_g = op_arr[gnt];
  assign a_g  = a_arr[gnt];
  assign b_g  = b_arr[gnt];

  // Shared gate array, one slice per bit.
  for (genvar j = 0; j < VEC_W; j++) begin : g_bit
    logic_unit_bit_slice u_slice (
      .op (op_g),
      .a  (a_g[j]),
      .b  (b_g[j]),
      .y  (y_g[j])
    );
  end

  // Output register and round-robin pointer; a new grant overwrites a
  // draining result so there is no bubble at full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_y16   <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_op    <= '0;
      last          <= IDW'(N_REQ - 1);
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_y16   <= y_g;
      bus.rsp_id    <= gnt;
      bus.rsp_op    <= op_g;
      last          <= gnt;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule
